// File: rtl/regs_file_lvt_init.sv
// Multi-port architectural register file: LVT-selected LUTRAM banks per (write, read) port pair,
// with a sequential zero sweep after reset or on a clear request.
module regs_file_lvt_init #(
    parameter int unsigned GPR_NUM     = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned WRITE_PORTS = 2,
    parameter int unsigned READ_PORTS  = 4,
    parameter int unsigned BYPASS_EN   = 1,
    parameter int unsigned ADDR_W      = $clog2(GPR_NUM)
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [WRITE_PORTS-1:0]                  we_i,
    input  logic [WRITE_PORTS-1:0][ADDR_W-1:0]      waddr_i,
    input  logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0]  wdata_i,
    input  logic [READ_PORTS-1:0]                   read_valid_i,
    input  logic [READ_PORTS-1:0][ADDR_W-1:0]       read_addr_i,
    output logic [READ_PORTS-1:0][DATA_WIDTH-1:0]   read_data_o,
    input  logic                                    clear_i,
    output logic                                    ready_o,
    output logic                                    clear_done_o
);

    localparam int unsigned LVT_W = (WRITE_PORTS > 1) ? $clog2(WRITE_PORTS) : 1;

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } state_t;

    state_t                                                   state;
    logic [ADDR_W-1:0]                                        sweep_cnt;
    logic                                                     sweep_we;
    logic                                                     wr_ok;
    logic [WRITE_PORTS-1:0]                                   wr_acc;
    logic [LVT_W-1:0]                                         lvt [GPR_NUM];
    logic [WRITE_PORTS-1:0][READ_PORTS-1:0][DATA_WIDTH-1:0]   bank_rd;

    // Sweep/idle controller; outputs are registered alongside the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= INIT;
            sweep_cnt    <= '0;
            ready_o      <= 1'b0;
            clear_done_o <= 1'b0;
        end else begin
            clear_done_o <= 1'b0;
            case (state)
                INIT: begin
                    sweep_cnt <= sweep_cnt + ADDR_W'(1);
                    if (sweep_cnt == ADDR_W'(GPR_NUM - 1)) begin
                        state        <= IDLE;
                        sweep_cnt    <= '0;
                        ready_o      <= 1'b1;
                        clear_done_o <= 1'b1;
                    end
                end
                IDLE: begin
                    if (clear_i) begin
                        state     <= INIT;
                        sweep_cnt <= '0;
                        ready_o   <= 1'b0;
                    end
                end
                default: begin
                    state     <= INIT;
                    sweep_cnt <= '0;
                    ready_o   <= 1'b0;
                end
            endcase
        end
    end

    assign sweep_we = (state == INIT);
    assign wr_ok    = (state == IDLE) && !clear_i;

    // Writes to r0 are never accepted so r0 always reads as zero
    always_comb begin
        wr_acc = '0;
        for (int unsigned w = 0; w < WRITE_PORTS; w++) begin
            wr_acc[w] = wr_ok && we_i[w] && (waddr_i[w] != '0);
        end
    end

    // One bank per (write port, read port); only row 0 is zeroed since the LVT points there after a sweep
    for (genvar w = 0; w < WRITE_PORTS; w++) begin : g_wr
        for (genvar r = 0; r < READ_PORTS; r++) begin : g_rd
            logic [DATA_WIDTH-1:0] mem [GPR_NUM];

            always_ff @(posedge clk) begin
                if (w == 0 && sweep_we) begin
                    mem[sweep_cnt] <= '0;
                end else if (wr_acc[w]) begin
                    mem[waddr_i[w]] <= wdata_i[w];
                end
            end

            assign bank_rd[w][r] = mem[read_addr_i[r]];
        end
    end

    // Live-value table: ascending loop lets the highest port index win on collisions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < GPR_NUM; i++) begin
                lvt[i] <= '0;
            end
        end else if (sweep_we) begin
            lvt[sweep_cnt] <= '0;
        end else begin
            for (int unsigned w = 0; w < WRITE_PORTS; w++) begin
                if (wr_acc[w]) begin
                    lvt[waddr_i[w]] <= LVT_W'(w);
                end
            end
        end
    end

    // Read mux with optional same-cycle forwarding, then the zero overrides
    always_comb begin
        read_data_o = '0;
        for (int unsigned r = 0; r < READ_PORTS; r++) begin
            read_data_o[r] = bank_rd[lvt[read_addr_i[r]]][r];
            if (BYPASS_EN != 0) begin
                for (int unsigned w = 0; w < WRITE_PORTS; w++) begin
                    if (wr_acc[w] && (waddr_i[w] == read_addr_i[r])) begin
                        read_data_o[r] = wdata_i[w];
                    end
                end
            end
            if (read_addr_i[r] == '0) begin
                read_data_o[r] = '0;
            end
            if (!read_valid_i[r]) begin
                read_data_o[r] = '0;
            end
            if (state == INIT) begin
                read_data_o[r] = '0;
            end
        end
    end

endmodule

// File: doc/regs_file_lvt_init.md
Name: regs_file_lvt_init

Overview:
- Next-generation architectural register file: generalises the LVT-based multi-port GPR file to parametrised register count, data width, write-port count and read-port count.
- Adds a hardware clear sweep. LUTRAM banks have no reset, so a sequential init FSM writes zero to every entry after reset or on a flush request.
- Sits between the commit stage (write ports) and dispatch/issue (read ports) of the core.

Parameters:
- GPR_NUM, 32, number of architectural registers; power of two, ≥ 4.
- DATA_WIDTH, 32, register width in bits.
- WRITE_PORTS, 2, number of write ports; ≥ 1.
- READ_PORTS, 4, number of read ports; ≥ 1.
- BYPASS_EN, 1, 1 = same-cycle write-to-read forwarding; 0 = reads return pre-write contents.
- ADDR_W, $clog2(GPR_NUM), derived address width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- we_i  in  WRITE_PORTS  per-port write enable
- waddr_i  in  WRITE_PORTS×ADDR_W  write addresses
- wdata_i  in  WRITE_PORTS×DATA_WIDTH  write data
- read_valid_i  in  READ_PORTS  per-port read enable
- read_addr_i  in  READ_PORTS×ADDR_W  read addresses
- read_data_o  out  READ_PORTS×DATA_WIDTH  read data, combinational
- clear_i  in  1  single-cycle request to zero the whole file
- ready_o  out  1  1 = file usable (IDLE state)
- clear_done_o  out  1  one-cycle pulse when a sweep completes

Behaviour:
- Storage:
  - WRITE_PORTS × READ_PORTS LUTRAM banks, one bank per (write port, read port) pair, no reset on the arrays.
  - Last-valid table (LVT): GPR_NUM entries of $clog2(WRITE_PORTS) bits (1 bit minimum). It records which write port last wrote each register.
  - LVT is built from flops and is reset asynchronously to 0.
- FSM states: INIT, IDLE.
  - rst_n low: state=INIT, sweep counter=0, ready_o=0, clear_done_o=0.
  - INIT, each cycle: write 0 to address counter in all bank-0 rows, set LVT[counter]=0, counter++.
  - INIT exit: when counter==GPR_NUM-1, next state is IDLE and clear_done_o pulses in the first IDLE cycle.
  - Sweep duration: exactly GPR_NUM cycles; ready_o rises on the cycle after the last sweep write.
  - IDLE: ready_o=1. clear_i=1 gives next state INIT with counter=0.
  - clear_i while in INIT: ignored; the sweep continues and does not restart.
  - rst_n asserted mid-sweep: sweep restarts from address 0 after deassertion.
- Writes:
  - Accepted only in IDLE with clear_i=0. In INIT, or in the cycle clear_i is asserted, all we_i are dropped with no LVT or bank update.
  - Accepted write on port w to address a: all banks of row w write wdata_i[w] at the next clock edge; LVT[a]=w.
  - Writes to address 0 are discarded; r0 stays 0.
  - Same address on several ports in one cycle: highest port index wins for both the LVT and the bypass.
- Reads (asynchronous, 0-cycle latency):
  - read_data_o[r] = bank[LVT[addr]][r][addr].
  - If BYPASS_EN=1 and an accepted write in the same cycle targets addr, forward its wdata (highest index wins).
  - Override order, last wins: addr==0 gives 0; read_valid_i[r]==0 gives 0; state==INIT gives 0.
- Outputs are 0 during reset except read_data_o, which is 0 via the INIT override.

Test Plan:
- Reset then idle (GPR_NUM=32): ready_o low exactly 32 cycles after rst_n rises; clear_done_o single pulse in cycle 33; read of r5 returns 0.
- Port 1 writes r3=0xDEADBEEF, then port 0 writes r3=0x12345678 next cycle: read r3 returns 0x12345678. A same-cycle dual write to r7 (p0=0x1, p1=0x2) reads back 0x2.
- BYPASS_EN=1, write r9=0xA5A5A5A5 and read r9 in the same cycle: read_data_o=0xA5A5A5A5. With BYPASS_EN=0 the same-cycle read returns the old value 0, and 0xA5A5A5A5 the next cycle.
- Write r0=0xFFFFFFFF, or read with read_valid_i=0 on r4 holding 0x44: read_data_o=0 in both cases.
- Fill r1..r31 with nonzero values, pulse clear_i together with a write r2=0x99: the write is dropped, ready_o=0 for 32 cycles, then every register reads 0.
- Assert rst_n low at sweep cycle 10 and release: ready_o stays low a full 32 cycles from release, and all reads return 0 afterwards.
